// File: rtl/btn_updown_counter.sv
// btn_updown_counter: two raw push-buttons, each synchronised and debounced,
// driving a bounded up/down counter with wrap or saturate behaviour.
// Optional hold-to-auto-repeat is built only when AUTO_REPEAT_EN is defined.
module btn_updown_counter #(
    parameter int WIDTH         = 4,
    parameter int DB_CYCLES     = 4,
    parameter int CNT_MIN       = 0,
    parameter int CNT_MAX       = 15,
    parameter bit WRAP          = 1'b1,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             btn_up_raw,
    input  logic             btn_dn_raw,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             dn_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam int DBW = $clog2(DB_CYCLES);
    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(CNT_MIN);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(CNT_MAX);
    localparam logic [DBW-1:0] L_DB_LAST = DBW'(DB_CYCLES - 1);

    // Reject configurations the counter and timers cannot represent.
    if (WIDTH < 2 || WIDTH > 16) begin : g_badWidth
        $error("btn_updown_counter: WIDTH must be 2..16");
    end
    if (DB_CYCLES < 2) begin : g_badDebounce
        $error("btn_updown_counter: DB_CYCLES must be >= 2");
    end
    if (CNT_MIN >= CNT_MAX || CNT_MAX > (2 ** WIDTH) - 1) begin : g_badLimits
        $error("btn_updown_counter: need CNT_MIN < CNT_MAX <= 2**WIDTH-1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badRepeat
        $error("btn_updown_counter: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // Index 0 is the up button, index 1 the down button throughout.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_level;
    logic [1:0]       r_levelPrev;
    logic [1:0]       r_pulse;
    logic [DBW-1:0]   r_dbCnt [2];
    logic [1:0]       w_rise;
    logic [1:0]       w_strobe;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_countNext;
    logic             r_atMax;
    logic             r_atMin;

    assign w_raw = {btn_dn_raw, btn_up_raw};

    // Two-flop synchronisers bring the asynchronous buttons into the clock domain.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a level change is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_level <= '0;
            for (int b = 0; b < 2; b++) begin
                r_dbCnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_level[b]) begin
                    r_dbCnt[b] <= '0;
                end else if (r_dbCnt[b] == L_DB_LAST) begin
                    r_level[b] <= ~r_level[b];
                    r_dbCnt[b] <= '0;
                end else begin
                    r_dbCnt[b] <= r_dbCnt[b] + DBW'(1);
                end
            end
        end
    end

    assign w_rise = r_level & ~r_levelPrev;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = $clog2(REP_MAX + 1);

    logic [TW-1:0] r_timer [2];
    logic [1:0]    r_armed;
    logic [1:0]    w_repeat;

    // A repeat fires when an armed hold timer has run down while the button is still held.
    always_comb begin
        w_repeat = '0;
        for (int b = 0; b < 2; b++) begin
            w_repeat[b] = r_armed[b] & r_level[b] & (r_timer[b] == '0);
        end
    end

    // Hold timers: load the initial delay on the first strobe, then reload the period after each repeat.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_armed <= '0;
            for (int b = 0; b < 2; b++) begin
                r_timer[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!r_level[b]) begin
                    r_armed[b] <= 1'b0;
                    r_timer[b] <= '0;
                end else if (w_rise[b]) begin
                    r_armed[b] <= 1'b1;
                    r_timer[b] <= TW'(REPEAT_DELAY - 1);
                end else if (r_armed[b]) begin
                    if (r_timer[b] == '0) begin
                        r_timer[b] <= TW'(REPEAT_PERIOD - 1);
                    end else begin
                        r_timer[b] <= r_timer[b] - TW'(1);
                    end
                end
            end
        end
    end

    assign w_strobe = w_rise | w_repeat;
`else
    assign w_strobe = w_rise;
`endif

    // Strobes are registered one cycle after the debounced rise (or repeat).
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_levelPrev <= '0;
            r_pulse     <= '0;
        end else begin
            r_levelPrev <= r_level;
            r_pulse     <= w_strobe;
        end
    end

    // Next count from the step rules; simultaneous up and down cancel out.
    always_comb begin
        w_countNext = r_count;
        if (r_pulse[0] && !r_pulse[1]) begin
            if (r_count == L_MAX) begin
                w_countNext = WRAP ? L_MIN : r_count;
            end else begin
                w_countNext = r_count + WIDTH'(1);
            end
        end else if (r_pulse[1] && !r_pulse[0]) begin
            if (r_count == L_MIN) begin
                w_countNext = WRAP ? L_MAX : r_count;
            end else begin
                w_countNext = r_count - WIDTH'(1);
            end
        end
    end

    // Count and its limit flags update together so the flags always describe the visible count.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            r_count <= L_MIN;
            r_atMax <= 1'b0;
            r_atMin <= 1'b1;
        end else begin
            r_count <= w_countNext;
            r_atMax <= (w_countNext == L_MAX);
            r_atMin <= (w_countNext == L_MIN);
        end
    end

    assign count    = r_count;
    assign up_pulse = r_pulse[0];
    assign dn_pulse = r_pulse[1];
    assign at_max   = r_atMax;
    assign at_min   = r_atMin;

endmodule

// File: tb/tb_btn_updown_counter.sv
// Testbench for btn_updown_counter: a wrapping instance (0..15) and a saturating
// instance (2..12) share the same buttons and are compared every cycle against a
// behavioural model, with literal checkpoints along directed scenarios.
module tb_btn_updown_counter;

    localparam int W    = 4;
    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam int MIN0 = 0;
    localparam int MAX0 = 15;
    localparam int MIN1 = 2;
    localparam int MAX1 = 12;

    logic clk   = 1'b0;
    logic rst_p = 1'b1;
    logic btnUp = 1'b0;
    logic btnDn = 1'b0;

    logic [W-1:0] count0, count1;
    logic up0, dn0, max0, min0;
    logic up1, dn1, max1, min1;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // Model state: raw samples since reset, debounced levels, strobes, counts.
    bit rawHist [2][$];
    bit lvl [2];
    bit lvlPrev [2];
    bit expPulse [2];
    int riseEdge [2];
    int edgeIdx;
    int expCnt [2];

    always #5 clk = ~clk;

    btn_updown_counter #(
        .WIDTH(W), .DB_CYCLES(DB), .CNT_MIN(MIN0), .CNT_MAX(MAX0), .WRAP(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dutWrap (
        .clk(clk), .rst_p(rst_p), .btn_up_raw(btnUp), .btn_dn_raw(btnDn),
        .count(count0), .up_pulse(up0), .dn_pulse(dn0), .at_max(max0), .at_min(min0)
    );

    btn_updown_counter #(
        .WIDTH(W), .DB_CYCLES(DB), .CNT_MIN(MIN1), .CNT_MAX(MAX1), .WRAP(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dutSat (
        .clk(clk), .rst_p(rst_p), .btn_up_raw(btnUp), .btn_dn_raw(btnDn),
        .count(count1), .up_pulse(up1), .dn_pulse(dn1), .at_max(max1), .at_min(min1)
    );

    // Step rule straight from the counter's definition.
    function automatic int nextCount(input int cur, input bit up, input bit dn,
                                     input int mn, input int mx, input bit wrap);
        if (up && !dn) return (cur == mx) ? (wrap ? mn : cur) : cur + 1;
        if (dn && !up) return (cur == mn) ? (wrap ? mx : cur) : cur - 1;
        return cur;
    endfunction

    task automatic modelReset();
        for (int b = 0; b < 2; b++) begin
            rawHist[b].delete();
            lvl[b]      = 1'b0;
            lvlPrev[b]  = 1'b0;
            expPulse[b] = 1'b0;
            riseEdge[b] = 0;
        end
        edgeIdx   = 0;
        expCnt[0] = MIN0;
        expCnt[1] = MIN1;
    endtask

    // One clock edge of the model. The raw sample taken at edge j is seen by the
    // debouncer at edge j+2; a level flips once the last DB such samples all disagree with it.
    task automatic modelEdge();
        bit raw [2];
        bit newPulse [2];
        bit allDiffer;
        raw[0] = btnUp;
        raw[1] = btnDn;
        edgeIdx++;
        expCnt[0] = nextCount(expCnt[0], expPulse[0], expPulse[1], MIN0, MAX0, 1'b1);
        expCnt[1] = nextCount(expCnt[1], expPulse[0], expPulse[1], MIN1, MAX1, 1'b0);
        for (int b = 0; b < 2; b++) begin
            newPulse[b] = lvl[b] && !lvlPrev[b];
            if (newPulse[b]) riseEdge[b] = edgeIdx;
`ifdef AUTO_REPEAT_EN
            else if (lvl[b] && riseEdge[b] > 0 && (edgeIdx - riseEdge[b]) >= RD &&
                     ((edgeIdx - riseEdge[b] - RD) % RP) == 0)
                newPulse[b] = 1'b1;
`endif
            if (!lvl[b]) riseEdge[b] = 0;
            lvlPrev[b] = lvl[b];
            if (edgeIdx >= DB + 2) begin
                allDiffer = 1'b1;
                for (int j = edgeIdx - 2 - DB; j <= edgeIdx - 3; j++) begin
                    if (rawHist[b][j] == lvl[b]) allDiffer = 1'b0;
                end
                if (allDiffer) lvl[b] = !lvl[b];
            end
            rawHist[b].push_back(raw[b]);
            expPulse[b] = newPulse[b];
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives both buttons and advances the given number of cycles on the drive grid.
    task automatic applyStimulus(input bit up, input bit dn, input int n);
        btnUp = up;
        btnDn = dn;
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic press(input bit up, input bit dn);
        applyStimulus(up, dn, DB + 2);
        applyStimulus(1'b0, 1'b0, DB + 6);
    endtask

    task automatic doReset();
        rst_p = 1'b1;
        applyStimulus(1'b0, 1'b0, 2);
        rst_p = 1'b0;
    endtask

    // Model advances on every clock edge and on asynchronous reset.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge rst_p);
            if (rst_p) modelReset();
            else modelEdge();
        end
    end

    // Compare both instances against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("count0", count0, expCnt[0]);
            checkOutput("atMax0", max0, expCnt[0] == MAX0);
            checkOutput("atMin0", min0, expCnt[0] == MIN0);
            checkOutput("upPulse0", up0, expPulse[0]);
            checkOutput("dnPulse0", dn0, expPulse[1]);
            checkOutput("count1", count1, expCnt[1]);
            checkOutput("atMax1", max1, expCnt[1] == MAX1);
            checkOutput("atMin1", min1, expCnt[1] == MIN1);
            checkOutput("upPulse1", up1, expPulse[0]);
            checkOutput("dnPulse1", dn1, expPulse[1]);
        end
    end

    initial begin
        bit seenBoth;

        // Reset state.
        applyStimulus(1'b0, 1'b0, 2);
        checkEn = 1'b1;
        rst_p = 1'b0;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rstCount0", count0, 0);
        checkOutput("rstAtMin0", min0, 1);
        checkOutput("rstAtMax0", max0, 0);
        checkOutput("rstCount1", count1, 2);

        // Single press: count steps after edge DB+4.
        doReset();
        btnUp = 1'b1;
        repeat (DB + 3) @(posedge clk);
        #1 checkOutput("latencyBefore", count0, 0);
        @(posedge clk);
        #1 checkOutput("latencyAfter", count0, 1);
        @(negedge clk);
        #2 applyStimulus(1'b0, 1'b0, DB + 8);

        // One-cycle toggling is rejected.
        for (int i = 0; i < 6; i++) applyStimulus(i[0] == 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("glitchCount0", count0, 1);

        // Climb to the limits: wrap instance reaches 15, saturating instance stops at 12.
        for (int i = 0; i < 14; i++) press(1'b1, 1'b0);
        checkOutput("climbCount0", count0, 15);
        checkOutput("climbAtMax0", max0, 1);
        checkOutput("climbCount1", count1, 12);
        checkOutput("climbAtMax1", max1, 1);
        press(1'b1, 1'b0);
        checkOutput("wrapUp0", count0, 0);
        checkOutput("satUp1", count1, 12);
        press(1'b0, 1'b1);
        checkOutput("wrapDn0", count0, 15);
        checkOutput("stepDn1", count1, 11);

        // Both buttons together from count 5: both strobes, count unchanged.
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
        checkOutput("setFive0", count0, 5);
        btnUp = 1'b1;
        btnDn = 1'b1;
        seenBoth = 1'b0;
        for (int i = 0; i < DB + 8 && !seenBoth; i++) begin
            @(negedge clk);
            if (up0) begin
                seenBoth = 1'b1;
                checkOutput("bothDnPulse", dn0, 1);
            end
        end
        checkOutput("bothSeen", seenBoth, 1);
        #2 applyStimulus(1'b0, 1'b0, DB + 8);
        checkOutput("bothCount0", count0, 5);
        checkOutput("bothCount1", count1, 12);

        // Down at the lower limit: wrap vs saturate.
        doReset();
        press(1'b0, 1'b1);
        checkOutput("dnWrap0", count0, 15);
        checkOutput("dnSat1", count1, 2);
        checkOutput("dnSatAtMin1", min1, 1);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        checkOutput("toThree0", count0, 3);

        // Reset mid-hold, button kept held through release.
        btnUp = 1'b1;
        applyStimulus(1'b1, 1'b0, 5);
        rst_p = 1'b1;
        #1 checkOutput("midRstCount0", count0, 0);
        checkOutput("midRstCount1", count1, 2);
        applyStimulus(1'b1, 1'b0, 2);
        rst_p = 1'b0;
        repeat (DB + 3) @(posedge clk);
        #1 checkOutput("reholdBefore", count0, 0);
        @(posedge clk);
        #1 checkOutput("reholdAfter", count0, 1);
        @(negedge clk);
        #2 applyStimulus(1'b0, 1'b0, DB + 8);

        // Randomised presses, bounces, overlaps and occasional resets.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_p = 1'b1;
                applyStimulus(btnUp, btnDn, $urandom_range(1, 2));
                rst_p = 1'b0;
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 14));
        end
        applyStimulus(1'b0, 1'b0, 20);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
